// File: rtl/kan_weight_loader_if.sv
// Stream and read-port bundle for the KAN weight loader.
// Master feeds words and issues reads; slave is the loader.
interface kan_weight_loader_if #(
  parameter int AW = 3
);
  logic          s_valid;
  logic [15:0]   s_data;
  logic          s_ready;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;

  modport master (
    output s_valid, s_data, rd_sel, rd_addr,
    input  s_ready, rd_data
  );

  modport slave (
    input  s_valid, s_data, rd_sel, rd_addr,
    output s_ready, rd_data
  );
endinterface

// File: rtl/kan_weight_loader.sv
// Loads base and spline weight RAMs from a checksummed word stream.
// Exposes a registered read port for the linear layer.
module kan_weight_loader #(
  parameter int IN_FEATURES  = 2,
  parameter int OUT_FEATURES = 3,
  parameter int AW = ((OUT_FEATURES * IN_FEATURES) > 1)
                     ? $clog2(OUT_FEATURES * IN_FEATURES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  kan_weight_loader_if.slave bus,
  output logic busy,
  output logic weights_valid,
  output logic err
);

  localparam int N = OUT_FEATURES * IN_FEATURES;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_BASE,
    LOAD_SPLINE,
    CHECK
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [15:0]   acc_q, acc_d;
  logic          wv_q, wv_d;
  logic          err_q, err_d;
  logic [15:0]   rd_data_q, rd_data_d;

  logic [15:0] base_mem [0:2**AW-1];
  logic [15:0] spl_mem  [0:2**AW-1];

  logic ready;
  logic fire;
  logic last;
  logic we_base;
  logic we_spl;

  assign fire = bus.s_valid && ready;
  assign last = (cnt_q == AW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wv_d    = wv_q;
    err_d   = err_q;
    ready   = 1'b0;
    we_base = 1'b0;
    we_spl  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_BASE;
          cnt_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
          wv_d    = 1'b0;
        end
      end
      LOAD_BASE, LOAD_SPLINE: begin
        ready = 1'b1;
        if (fire) begin
          we_base = (state_q == LOAD_BASE);
          we_spl  = (state_q == LOAD_SPLINE);
          acc_d   = acc_q + bus.s_data;
          if (last) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_BASE)
                      ? LOAD_SPLINE : CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        ready = 1'b1;
        if (fire) begin
          if (bus.s_data == acc_q) wv_d = 1'b1;
          else                     err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range addresses read as zero rather than stale RAM.
  always_comb begin
    rd_data_d = '0;
    if (int'(bus.rd_addr) < N) begin
      rd_data_d = bus.rd_sel ? spl_mem[bus.rd_addr]
                             : base_mem[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      wv_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wv_q      <= wv_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAMs keep contents across reset; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (reset && we_base) base_mem[cnt_q] <= bus.s_data;
    if (reset && we_spl)  spl_mem[cnt_q]  <= bus.s_data;
  end

  assign bus.s_ready   = ready;
  assign bus.rd_data   = rd_data_q;
  assign busy          = (state_q != IDLE);
  assign weights_valid = wv_q;
  assign err           = err_q;

endmodule

// File: tb/tb_kan_weight_loader.sv
// Randomized self-checking bench for kan_weight_loader.
// A frame-level model tracks RAM contents and checksum outcome.
module tb_kan_weight_loader;

  localparam int INF  = 2;
  localparam int OUTF = 3;
  localparam int N    = INF * OUTF;
  localparam int AW   = 3;
  localparam int FW   = 2 * N + 1;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic weights_valid;
  logic err;

  kan_weight_loader_if #(.AW(AW)) bus ();

  kan_weight_loader #(
    .IN_FEATURES (INF),
    .OUT_FEATURES(OUTF),
    .AW          (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .weights_valid(weights_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] fw    [0:FW-1];
  logic [15:0] mbase [0:N-1];
  logic [15:0] mspl  [0:N-1];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [15:0] frame_sum();
    logic [15:0] s = '0;
    for (int i = 0; i < 2 * N; i++) s += fw[i];
    return s;
  endfunction

  // kind 0: fixed ramp, 1: random, 2: all ones
  task automatic fill_frame(input int kind);
    for (int i = 0; i < 2 * N; i++) begin
      case (kind)
        0:       fw[i] = (i < N) ? 16'(i + 1)
                                 : 16'((i - N + 1) * 16);
        2:       fw[i] = 16'hFFFF;
        default: fw[i] = 16'($urandom);
      endcase
    end
    fw[2*N] = frame_sum();
  endtask

  task automatic send_word(input logic [15:0] w,
                           input bit bub);
    int t = 0;
    if (bub) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 16'($urandom);
        tick();
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    while (!bus.s_ready && t < 40) begin
      tick();
      t++;
    end
    if (!bus.s_ready) check("stall_timeout", 0, 1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic read_all(input string tag);
    logic [15:0] e;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 2 ** AW; a++) begin
        bus.rd_sel  = s[0];
        bus.rd_addr = AW'(a);
        tick();
        if (a >= N)      e = '0;
        else if (s == 0) e = mbase[a];
        else             e = mspl[a];
        check($sformatf("%s_rd_s%0d_a%0d", tag, s, a),
              32'(bus.rd_data), 32'(e));
      end
    end
  endtask

  task automatic run_frame(input string tag,
                           input bit bub,
                           input int start_at,
                           input int rst_at,
                           input bit rbw);
    logic [15:0] old;
    logic        ok;
    ok = (fw[2*N] == frame_sum());
    pulse_start();
    check({tag, "_busy_start"}, 32'(busy), 1);
    check({tag, "_err_clr"}, 32'(err), 0);
    check({tag, "_wv_clr"}, 32'(weights_valid), 0);
    for (int i = 0; i < FW; i++) begin
      if (i == rst_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_wv"}, 32'(weights_valid), 0);
        check({tag, "_rst_rdy"}, 32'(bus.s_ready), 0);
        return;
      end
      if (i == start_at) begin
        pulse_start();
        check({tag, "_start_ign"}, 32'(busy), 1);
      end
      if (rbw && i == 0) begin
        old         = mbase[0];
        bus.rd_sel  = 1'b0;
        bus.rd_addr = '0;
        send_word(fw[0], 1'b0);
        check({tag, "_rbw_old"}, 32'(bus.rd_data), 32'(old));
        tick();
        check({tag, "_rbw_new"}, 32'(bus.rd_data), 32'(fw[0]));
      end else begin
        send_word(fw[i], bub);
      end
      if (i < N)          mbase[i] = fw[i];
      else if (i < 2 * N) mspl[i-N] = fw[i];
    end
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_rdy_end"}, 32'(bus.s_ready), 0);
    check({tag, "_wv"}, 32'(weights_valid), 32'(ok));
    check({tag, "_err"}, 32'(err), 32'(!ok));
  endtask

  task automatic hold_dead();
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    repeat (3) begin
      tick();
      check("idle_no_ready", 32'(bus.s_ready), 0);
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.rd_sel  = 1'b0;
    bus.rd_addr = '0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_wv", 32'(weights_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdy", 32'(bus.s_ready), 0);
    check("rst_rd", 32'(bus.rd_data), 0);
    reset = 1'b1;

    hold_dead();
    fill_frame(0);
    run_frame("good", 1'b0, -1, -1, 1'b0);
    read_all("good");

    hold_dead();
    read_all("dead");

    fill_frame(0);
    fw[2*N] = fw[2*N] - 16'd1;
    run_frame("bad", 1'b0, -1, -1, 1'b0);
    read_all("bad");

    fill_frame(2);
    run_frame("wrap", 1'b1, -1, -1, 1'b0);
    check("wrap_sum", 32'(fw[2*N]), 32'h0000FFF4);

    fill_frame(1);
    run_frame("midstart", 1'b1, 3, -1, 1'b0);
    read_all("midstart");

    for (int k = 0; k < 3; k++) begin
      fill_frame(1);
      if ($urandom_range(0, 1) == 1)
        fw[2*N] = fw[2*N] ^ 16'(1 << $urandom_range(0, 15));
      run_frame($sformatf("rnd%0d", k), 1'b1, -1, -1, 1'b0);
    end
    read_all("rnd");

    fill_frame(1);
    run_frame("abort", 1'b1, -1, 8, 1'b0);
    read_all("abort");

    fill_frame(1);
    fw[0]   = mbase[0] ^ 16'h5A5A;
    fw[2*N] = frame_sum();
    run_frame("reload", 1'b1, -1, -1, 1'b1);
    read_all("reload");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
